// File: rtl/hilo_pkg.sv
// hilo_pkg: control codes, FSM states and iteration count shared by the HI/LO multiply/divide unit.
package hilo_pkg;
   localparam logic [3:0] CTL_DIV   = 4'd13;
   localparam logic [3:0] CTL_MULT  = 4'd14;
   localparam logic [3:0] CTL_MULTU = 4'd15;
   localparam int ITERS = 32;
   localparam int CNT_W = $clog2(ITERS);
   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
endpackage

// File: rtl/hilo_muldiv_div_step.sv
// div_step: one restoring-divide step on the shifted partial remainder.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   part,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem,
   output logic             q
);
   logic [WIDTH:0] diff;
   assign diff = part - {1'b0, divisor};
   assign q    = part >= {1'b0, divisor};
   // Remainder always ends below the divisor, so WIDTH bits suffice.
   assign rem  = q ? diff[WIDTH-1:0] : part[WIDTH-1:0];
endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: iterative MULT/MULTU/DIV unit owning the HI/LO registers.
module hilo_muldiv #(
   parameter int         WIDTH     = 32,
   parameter logic [3:0] CTL_DIV   = hilo_pkg::CTL_DIV,
   parameter logic [3:0] CTL_MULT  = hilo_pkg::CTL_MULT,
   parameter logic [3:0] CTL_MULTU = hilo_pkg::CTL_MULTU
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             hilo_enable,
   input  logic [3:0]       alu_ctl,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             kill,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);
   import hilo_pkg::*;
   state_t             state, state_nx;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] acc, prod;
   logic [WIDTH-1:0]   opnd, a_raw, abs_a, abs_b, rem_nx, res_hi, res_lo;
   logic [WIDTH:0]     sum;
   logic               is_div, dz, neg_hi, neg_lo, valid_ctl, accept, sgn, q_bit;

   assign valid_ctl = alu_ctl == CTL_DIV || alu_ctl == CTL_MULT || alu_ctl == CTL_MULTU;
   assign accept    = state == IDLE && hilo_enable && valid_ctl && !kill;
   assign sgn       = alu_ctl != CTL_MULTU;
   assign abs_a     = sgn && op_a[WIDTH-1] ? -op_a : op_a;
   assign abs_b     = sgn && op_b[WIDTH-1] ? -op_b : op_b;
   assign busy      = state != IDLE;

   // Multiply: acc = {partial product, remaining multiplier bits}.
   assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd & {WIDTH{acc[0]}}};

   // Divide: acc = {partial remainder, dividend bits shifting into quotient}.
   div_step #(.WIDTH(WIDTH)) u_step (
      .part    ({acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]}),
      .divisor (opnd),
      .rem     (rem_nx),
      .q       (q_bit)
   );

   assign prod   = neg_lo ? -acc : acc;
   assign res_lo = dz ? '1 : is_div ? (neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]) : prod[WIDTH-1:0];
   assign res_hi = dz ? a_raw : is_div ? (neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH])
                                       : prod[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;

   always_comb begin
      state_nx = state;
      if (accept)                          state_nx = RUN;
      else if (state != IDLE && kill)      state_nx = IDLE;
      else if (state == RUN && cnt == '0)  state_nx = FIX;
      else if (state == FIX)               state_nx = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         hi     <= '0;
         lo     <= '0;
         done   <= 1'b0;
         cnt    <= '0;
         acc    <= '0;
         opnd   <= '0;
         a_raw  <= '0;
         is_div <= 1'b0;
         dz     <= 1'b0;
         neg_hi <= 1'b0;
         neg_lo <= 1'b0;
      end else begin
         done <= state == FIX && !kill;
         if (state == IDLE && hi_we) hi <= wdata;
         if (state == IDLE && lo_we) lo <= wdata;
         if (accept) begin
            is_div <= alu_ctl == CTL_DIV;
            dz     <= alu_ctl == CTL_DIV && op_b == '0;
            a_raw  <= op_a;
            neg_lo <= sgn && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            neg_hi <= sgn && op_a[WIDTH-1];
            cnt    <= CNT_W'(ITERS - 1);
            acc    <= {{WIDTH{1'b0}}, alu_ctl == CTL_DIV ? abs_a : abs_b};
            opnd   <= alu_ctl == CTL_DIV ? abs_b : abs_a;
         end else if (state == RUN) begin
            cnt <= cnt - CNT_W'(1);
            acc <= is_div ? {rem_nx, acc[WIDTH-2:0], q_bit} : {sum, acc[WIDTH-1:1]};
         end
         if (state == FIX && !kill) begin
            hi <= res_hi;
            lo <= res_lo;
         end
      end
endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: scoreboard bench; stimulus pushes expected HI/LO, a monitor pops on each done.
module tb_hilo_muldiv;
   import hilo_pkg::*;
   localparam int W = 32;

   typedef struct packed {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } exp_t;

   logic         clk = 1'b0, rst_n = 1'b1, hilo_enable = 1'b0, kill = 1'b0;
   logic         hi_we = 1'b0, lo_we = 1'b0, prev_done = 1'b0;
   logic [3:0]   alu_ctl = 4'd0;
   logic [W-1:0] op_a = '0, op_b = '0, wdata = '0, hi, lo;
   logic         busy, done;
   exp_t         sb[$];
   int           n_vec = 0, n_bad = 0;

   always #5 clk = ~clk;

   hilo_muldiv dut (
      .clk(clk), .rst_n(rst_n), .hilo_enable(hilo_enable), .alu_ctl(alu_ctl),
      .op_a(op_a), .op_b(op_b), .kill(kill), .hi_we(hi_we), .lo_we(lo_we),
      .wdata(wdata), .hi(hi), .lo(lo), .busy(busy), .done(done)
   );

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_done: got done=1 expected no pending result");
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result_hi", hi, e.hi);
            check("result_lo", lo, e.lo);
         end
         if (prev_done) begin
            n_vec++;
            n_bad++;
            $display("FAIL done_width: got done high 2 cycles expected 1");
         end
      end
      prev_done = rst_n && done;
   end

   task automatic start(input logic [3:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic push, input logic [W-1:0] ehi, input logic [W-1:0] elo);
      @(negedge clk);
      hilo_enable = 1'b1;
      alu_ctl = ctl;
      op_a = a;
      op_b = b;
      if (push) sb.push_back({ehi, elo});
      @(posedge clk);
      #1 hilo_enable = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int exp_cyc);
      int c = 0;
      @(negedge clk);
      while (busy && c < 200) begin
         c++;
         @(negedge clk);
      end
      check(name, W'(c), W'(exp_cyc));
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      #1 rst_n = 1'b0;
      #2;
      check("reset_hi", hi, 32'h0);
      check("reset_lo", lo, 32'h0);
      check("reset_busy", W'(busy), 32'h0);
      check("reset_done", W'(done), 32'h0);
      @(negedge clk) rst_n = 1'b1;

      @(negedge clk);
      hilo_enable = 1'b1; alu_ctl = 4'd2; op_a = 32'd1; op_b = 32'd1;
      @(negedge clk);
      check("ignored_ctl_busy", W'(busy), 32'h0);
      hilo_enable = 1'b0;

      start(CTL_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      wait_idle("mult_latency", 33);
      check("mult_done_high", W'(done), 32'h1);
      @(negedge clk);
      check("mult_done_low", W'(done), 32'h0);

      @(negedge clk);
      hilo_enable = 1'b1; alu_ctl = CTL_MULTU; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF;
      sb.push_back({32'hFFFF_FFFE, 32'h0000_0001});
      @(posedge clk);
      #1 alu_ctl = CTL_MULT; op_a = 32'hFFFF_FFFE; op_b = 32'd3;
      sb.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFA});
      wait_idle("multu_latency", 33);
      @(posedge clk);
      #1 hilo_enable = 1'b0;
      check("held_req_accept", W'(busy), 32'h1);
      wait_idle("held_mult_latency", 33);

      start(CTL_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      wait_idle("div_neg_latency", 33);
      start(CTL_DIV, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14);
      wait_idle("div_pos_latency", 33);
      start(CTL_DIV, 32'd5, 32'd0, 1'b1, 32'd5, 32'hFFFF_FFFF);
      wait_idle("div_zero_latency", 33);
      start(CTL_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h8000_0000);
      wait_idle("div_ovf_latency", 33);

      @(negedge clk); hi_we = 1'b1; wdata = 32'h1234;
      @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5678;
      @(negedge clk); lo_we = 1'b0;
      check("mthi", hi, 32'h1234);
      check("mtlo", lo, 32'h5678);

      start(CTL_DIV, 32'd100, 32'd7, 1'b0, 32'h0, 32'h0);
      @(negedge clk); hi_we = 1'b1; wdata = 32'hAA;
      @(negedge clk); hi_we = 1'b0;
      repeat (8) @(negedge clk);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      check("kill_busy", W'(busy), 32'h0);
      check("kill_hi", hi, 32'h1234);
      check("kill_lo", lo, 32'h5678);
      repeat (3) @(negedge clk);
      check("kill_no_done", W'(done), 32'h0);

      hilo_enable = 1'b1; alu_ctl = CTL_MULT; kill = 1'b1;
      @(negedge clk);
      check("kill_blocks_accept", W'(busy), 32'h0);
      hilo_enable = 1'b0; kill = 1'b0;

      start(CTL_MULT, 32'd5, 32'd5, 1'b0, 32'h0, 32'h0);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_hi", hi, 32'h0);
      check("async_rst_lo", lo, 32'h0);
      check("async_rst_busy", W'(busy), 32'h0);
      check("async_rst_done", W'(done), 32'h0);
      @(negedge clk) rst_n = 1'b1;

      start(CTL_MULT, 32'd6, 32'd7, 1'b1, 32'h0, 32'd42);
      wait_idle("mult67_latency", 33);
      @(negedge clk);
      check("sb_drained", W'(sb.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
